// File: rtl/ram_responder.sv
// Halfword RAM responder: host preload in LOAD, core read/write in RUN; optional power-up clear under RAM_RESPONDER_CLEAR_EN.
// Latency: read data READ_LATENCY cycles after the address, one address accepted every cycle, write-first forwarding.
// Backpressure: none toward the core; host_load_ready is high for all of LOAD (zero-wait preload), low otherwise.
module ram_responder #(
    parameter int ADDR_BITS    = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ram_rd_addr_in,
    output logic [15:0] ram_rd_data_out,
    input  logic        ram_wr_en_in,
    input  logic [31:0] ram_wr_addr_in,
    input  logic [15:0] ram_wr_data_in,
    input  logic        host_load_valid,
    output logic        host_load_ready,
    input  logic [31:0] host_load_addr,
    input  logic [15:0] host_load_data,
    input  logic        host_load_done,
    output logic        core_hold,
    output logic        addr_fault
);
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
`ifdef RAM_RESPONDER_CLEAR_EN
    localparam logic [1:0]           ST_CLEAR = 2'd0;
    localparam logic [ADDR_BITS-1:0] IDX_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] IDX_LAST = {ADDR_BITS{1'b1}};
    logic [ADDR_BITS-1:0] clr_idx;
`endif

    logic [1:0]           state;
    logic [15:0]          mem [DEPTH];
    logic [15:0]          pipe [READ_LATENCY];
    logic                 is_load;
    logic                 is_run;
    logic                 rd_oor;
    logic                 wr_oor;
    logic                 host_oor;
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [ADDR_BITS-1:0] host_idx;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_widx;
    logic [15:0]          mem_wdat;
    logic [15:0]          rd_val;
    logic                 fault_set;

    assign is_load = (state == ST_LOAD);
    assign is_run  = (state == ST_RUN);

    assign host_load_ready = is_load;
    assign core_hold       = !is_run;

    // Byte addresses: bit 0 is dropped, anything above the array span is out of range.
    assign rd_oor   = (ram_rd_addr_in >> (ADDR_BITS + 1)) != 32'd0;
    assign wr_oor   = (ram_wr_addr_in >> (ADDR_BITS + 1)) != 32'd0;
    assign host_oor = (host_load_addr >> (ADDR_BITS + 1)) != 32'd0;
    assign rd_idx   = ram_rd_addr_in[ADDR_BITS:1];
    assign wr_idx   = ram_wr_addr_in[ADDR_BITS:1];
    assign host_idx = host_load_addr[ADDR_BITS:1];

    // Single array write port, owned by whichever agent the state grants it to.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = '0;
        mem_wdat = '0;
`ifdef RAM_RESPONDER_CLEAR_EN
        if (state == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_widx = clr_idx;
        end else
`endif
        if (is_load) begin
            mem_we   = host_load_valid && !host_oor;
            mem_widx = host_idx;
            mem_wdat = host_load_data;
        end else if (is_run) begin
            mem_we   = ram_wr_en_in && !wr_oor;
            mem_widx = wr_idx;
            mem_wdat = ram_wr_data_in;
        end
    end

    assign fault_set = (is_load && host_load_valid && host_oor) ||
                       (is_run && ((ram_wr_en_in && wr_oor) || rd_oor));

    always_comb begin
        rd_val = '0;
        if (is_run && !rd_oor) begin
            if (mem_we && (mem_widx == rd_idx)) begin
                rd_val = mem_wdat;
            end else begin
                rd_val = mem[rd_idx];
            end
        end
    end

    // The array is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef RAM_RESPONDER_CLEAR_EN
            state   <= ST_CLEAR;
            clr_idx <= '0;
`else
            state   <= ST_LOAD;
`endif
        end else begin
            case (state)
`ifdef RAM_RESPONDER_CLEAR_EN
                ST_CLEAR: begin
                    clr_idx <= clr_idx + IDX_ONE;
                    if (clr_idx == IDX_LAST) begin
                        state <= ST_LOAD;
                    end
                end
`endif
                ST_LOAD: begin
                    if (host_load_done) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_fault <= 1'b0;
        end else if (fault_set) begin
            addr_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= rd_val;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign ram_rd_data_out = pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: preload, RUN vector table through a read-data scoreboard, fault and reset sequences.
module tb_ram_responder;
    localparam int AB = 12;
    localparam int RL = 2;
`ifdef RAM_RESPONDER_CLEAR_EN
    localparam logic READY_AT_RESET = 1'b0;
`else
    localparam logic READY_AT_RESET = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ram_rd_addr_in = '0;
    logic [15:0] ram_rd_data_out;
    logic        ram_wr_en_in = 1'b0;
    logic [31:0] ram_wr_addr_in = '0;
    logic [15:0] ram_wr_data_in = '0;
    logic        host_load_valid = 1'b0;
    logic        host_load_ready;
    logic [31:0] host_load_addr = '0;
    logic [15:0] host_load_data = '0;
    logic        host_load_done = 1'b0;
    logic        core_hold;
    logic        addr_fault;

    ram_responder #(.ADDR_BITS(AB), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n),
        .ram_rd_addr_in(ram_rd_addr_in), .ram_rd_data_out(ram_rd_data_out),
        .ram_wr_en_in(ram_wr_en_in), .ram_wr_addr_in(ram_wr_addr_in), .ram_wr_data_in(ram_wr_data_in),
        .host_load_valid(host_load_valid), .host_load_ready(host_load_ready),
        .host_load_addr(host_load_addr), .host_load_data(host_load_data),
        .host_load_done(host_load_done), .core_hold(core_hold), .addr_fault(addr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [15:0] val;
        string       nm;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [15:0] wd;
        logic        hv;
        logic [31:0] ha;
        logic [15:0] hd;
        logic        dn;
        logic [31:0] ra;
        logic [15:0] ex;
        string       nm;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // After an edge the output shows the read issued RL-1 cycles earlier; the reset pipeline supplies zeros.
    task automatic sb_reset();
        exp_t e;
        sb.delete();
        for (int i = 0; i < RL - 1; i++) begin
            e.chk = 1'b1; e.val = 16'h0; e.nm = "rd_after_reset";
            sb.push_back(e);
        end
    endtask

    task automatic step(input logic chk, input logic [15:0] ex, input string nm);
        exp_t e;
        e.chk = chk; e.val = ex; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk) check(e.nm, {16'h0, ram_rd_data_out}, {16'h0, e.val});
    endtask

    task automatic idle();
        ram_wr_en_in = 1'b0; ram_wr_addr_in = '0; ram_wr_data_in = '0;
        host_load_valid = 1'b0; host_load_addr = '0; host_load_data = '0;
        host_load_done = 1'b0; ram_rd_addr_in = '0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [15:0] d, input logic dn);
        idle();
        host_load_valid = 1'b1; host_load_addr = a; host_load_data = d; host_load_done = dn;
        ram_rd_addr_in = 32'h0000_0002;
        check("ready_in_load", host_load_ready, 1'b1);
        step(1'b1, 16'h0, "load_rd_zero");
        idle();
    endtask

    task automatic row(input logic we, input logic [31:0] wa, input logic [15:0] wd,
                       input logic hv, input logic [31:0] ha, input logic [15:0] hd, input logic dn,
                       input logic [31:0] ra, input logic [15:0] ex, input string nm);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.hv = hv; r.ha = ha; r.hd = hd;
        r.dn = dn; r.ra = ra; r.ex = ex; r.nm = nm;
        vt.push_back(r);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        idle();
        host_load_valid = 1'b1; host_load_addr = 32'h0000_1234; host_load_data = 16'hEEEE;
        while (!host_load_ready && n < 5000) begin
            step(1'b0, 16'h0, "");
            n++;
        end
        idle();
        check("clear_cycles", n, 4096);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        row(0, 0, 0,              0, 0, 0, 0, 32'h0002, 16'hBEEF, "run_first_rd");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0000, 16'h1234, "rd_0000");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0010, 16'hA5A5, "rd_0010");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0011, 16'hA5A5, "rd_0011_bit0");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0100, 16'h7777, "rd_done_beat");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0102, 16'h2222, "rd_load_isolation");
        row(1, 32'h0040, 16'h5555, 0, 0, 0, 0, 32'h0040, 16'h5555, "rdw_forward");
        row(1, 32'h0042, 16'h0F0F, 0, 0, 0, 0, 32'h0040, 16'h5555, "rd_other_idx");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0042, 16'h0F0F, "rd_0042");
        row(1, 32'h0044, 16'hAAAA, 0, 0, 0, 0, 32'h0045, 16'hAAAA, "fwd_bit0");
        row(1, 32'h1FFE, 16'hC3C3, 0, 0, 0, 0, 32'h1FFE, 16'hC3C3, "last_idx_fwd");
        row(0, 0, 0,              0, 0, 0, 0, 32'h1FFF, 16'hC3C3, "last_idx_rd");
        row(0, 32'h0040, 16'h6666, 0, 0, 0, 0, 32'h0040, 16'h5555, "wr_en_low");
        row(0, 0, 0,              1, 32'h0042, 16'hDEAD, 1, 32'h0044, 16'hAAAA, "host_in_run");
        row(0, 0, 0,              0, 0, 0, 0, 32'h0042, 16'h0F0F, "host_ignored");

        reset_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", ram_rd_data_out, 16'h0);
        check("rst_fault", addr_fault, 1'b0);
        check("rst_hold", core_hold, 1'b1);
        check("rst_ready", host_load_ready, READY_AT_RESET);
        reset_n = 1'b1;
        sb_reset();
`ifdef RAM_RESPONDER_CLEAR_EN
        wait_ready();
`endif

        beat(32'h0000, 16'h1234, 1'b0);
        beat(32'h0002, 16'hBEEF, 1'b0);
        beat(32'h0010, 16'hA5A5, 1'b0);
        beat(32'h0102, 16'h2222, 1'b0);
        ram_wr_en_in = 1'b1; ram_wr_addr_in = 32'h0102; ram_wr_data_in = 16'h1111;
        ram_rd_addr_in = 32'h0102;
        step(1'b1, 16'h0, "load_core_rd");
        idle();
        check("hold_before_done", core_hold, 1'b1);
        beat(32'h0100, 16'h7777, 1'b1);
        check("hold_after_done", core_hold, 1'b0);
        check("ready_after_done", host_load_ready, 1'b0);

        foreach (vt[i]) begin
            ram_wr_en_in = vt[i].we; ram_wr_addr_in = vt[i].wa; ram_wr_data_in = vt[i].wd;
            host_load_valid = vt[i].hv; host_load_addr = vt[i].ha; host_load_data = vt[i].hd;
            host_load_done = vt[i].dn; ram_rd_addr_in = vt[i].ra;
            check("hold_run", core_hold, 1'b0);
            step(1'b1, vt[i].ex, vt[i].nm);
        end
        idle();
        check("no_fault_in_range", addr_fault, 1'b0);

        ram_wr_en_in = 1'b1; ram_wr_addr_in = 32'h0000_2000; ram_wr_data_in = 16'hFFFF;
        ram_rd_addr_in = 32'h0000;
        step(1'b1, 16'h1234, "oor_wr_no_alias_fwd");
        idle();
        check("fault_after_oor_wr", addr_fault, 1'b1);
        ram_rd_addr_in = 32'h0000_2000;
        step(1'b1, 16'h0, "oor_rd_zero");
        ram_rd_addr_in = 32'h0000_0000;
        step(1'b1, 16'h1234, "idx0_unchanged");
        ram_rd_addr_in = 32'hFFFF_0000;
        step(1'b1, 16'h0, "oor_rd_high");
        ram_rd_addr_in = 32'h0000_0000;
        repeat (RL) step(1'b1, 16'h1234, "rd_after_oor");
        check("fault_sticky", addr_fault, 1'b1);

        ram_rd_addr_in = 32'h0002;
        step(1'b1, 16'hBEEF, "inflight_a");
        step(1'b1, 16'hBEEF, "inflight_b");
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_data", ram_rd_data_out, 16'h0);
        check("midrst_fault", addr_fault, 1'b0);
        check("midrst_hold", core_hold, 1'b1);
        check("midrst_ready", host_load_ready, READY_AT_RESET);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_rd_held", ram_rd_data_out, 16'h0);
        reset_n = 1'b1;
        sb_reset();
`ifdef RAM_RESPONDER_CLEAR_EN
        wait_ready();
`endif
        check("ready_after_rst", host_load_ready, 1'b1);
        beat(32'h0000_4000, 16'h9999, 1'b0);
        check("fault_host_oor", addr_fault, 1'b1);
        host_load_done = 1'b1;
        step(1'b1, 16'h0, "done_no_beat");
        idle();
        check("hold_after_done2", core_hold, 1'b0);
`ifdef RAM_RESPONDER_CLEAR_EN
        ram_rd_addr_in = 32'h1234;
        step(1'b1, 16'h0, "cleared_1234");
        ram_rd_addr_in = 32'h0000;
        step(1'b1, 16'h0, "cleared_0000");
        ram_rd_addr_in = 32'h0040;
        step(1'b1, 16'h0, "cleared_0040");
`else
        ram_rd_addr_in = 32'h0000;
        step(1'b1, 16'h1234, "retained_0000");
        ram_rd_addr_in = 32'h0040;
        step(1'b1, 16'h5555, "retained_0040");
`endif
        ram_rd_addr_in = 32'h0000;
        repeat (RL) step(1'b0, 16'h0, "");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
